// File: rtl/serial_mag_comparator_if.sv
// rtl/serial_mag_comparator_if.sv - request/result bundle for the serial magnitude comparator
interface serial_mag_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin_g;
    logic             cin_l;
    logic             cin_e;
    logic             busy;
    logic             done;
    logic             G;
    logic             L;
    logic             E;

    modport master (
        output start, a, b, cin_g, cin_l, cin_e,
        input  busy, done, G, L, E
    );

    modport slave (
        input  start, a, b, cin_g, cin_l, cin_e,
        output busy, done, G, L, E
    );
endinterface

// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - nibble-serial cascadable magnitude comparator (G/L/E)
module serial_mag_comparator #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_mag_comparator_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             acc_g_q, acc_g_d;
    logic             acc_l_q, acc_l_d;
    logic             acc_e_q, acc_e_d;
    logic             out_g_q, out_g_d;
    logic             out_l_q, out_l_d;
    logic             out_e_q, out_e_d;

    // Operands shift right each RUN cycle, so the current nibble is always bits [3:0].
    logic [3:0] nib_a, nib_b;
    logic       nib_gt, nib_lt, nib_eq;
    logic       upd_g, upd_l, upd_e;

    assign nib_a  = a_q[3:0];
    assign nib_b  = b_q[3:0];
    assign nib_gt = (nib_a > nib_b);
    assign nib_lt = (nib_a < nib_b);
    assign nib_eq = (nib_a == nib_b);
    assign upd_g  = nib_gt | (nib_eq & acc_g_q);
    assign upd_l  = nib_lt | (nib_eq & acc_l_q);
    assign upd_e  = nib_eq & acc_e_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_g_d = acc_g_q;
        acc_l_d = acc_l_q;
        acc_e_d = acc_e_q;
        out_g_d = out_g_q;
        out_l_d = out_l_q;
        out_e_d = out_e_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_g_d = bus.cin_g;
                    acc_l_d = bus.cin_l;
                    acc_e_d = bus.cin_e;
                end
            end
            RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                acc_g_d = upd_g;
                acc_l_d = upd_l;
                acc_e_d = upd_e;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                    out_g_d = upd_g;
                    out_l_d = upd_l;
                    out_e_d = upd_e;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_g_q <= 1'b0;
            acc_l_q <= 1'b0;
            acc_e_q <= 1'b0;
            out_g_q <= 1'b0;
            out_l_q <= 1'b0;
            out_e_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_g_q <= acc_g_d;
            acc_l_q <= acc_l_d;
            acc_e_q <= acc_e_d;
            out_g_q <= out_g_d;
            out_l_q <= out_l_d;
            out_e_q <= out_e_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.G    = out_g_q;
    assign bus.L    = out_l_q;
    assign bus.E    = out_e_q;
endmodule
